mc_seqregs: RTL
===============

# mc_seqregs

Sequential datapath register stage for the multicycle ARM processor. It sits directly downstream of the main control FSM and condition logic. It holds the PC, the instruction register, and the non-architectural Data, A, B and ALUOut registers. It also steers the address, ALU-operand and result multiplexers under the FSM's control fields, and returns the latched instruction to the controller.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clock clk
- NextPC  in  1  FSM request to write PC (fetch increment)
- PCSrc  in  1  condition-qualified branch/PC write from condition logic
- IRWrite  in  1  load instruction register from ReadData
- AdrSrc  in  1  memory address select: 0 = PC, 1 = Result
- ALUSrcA  in  2  SrcA select: 00 = A, 01 = PC, 10 = ALUOut, 11 = 0
- ALUSrcB  in  2  SrcB select: 00 = B, 01 = ExtImm, 10 = 32'd4, 11 = 0
- ResultSrc  in  2  Result select: 00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = ALUOut
- ReadData  in  32  unified memory read data
- RD1  in  32  register-file read port 1
- RD2  in  32  register-file read port 2
- ExtImm  in  32  extended immediate
- ALUResult  in  32  ALU output
- PC  out  32  program counter register
- Instr  out  32  instruction register (Cond/Op/Funct/Rd fields go to controller and register file)
- Adr  out  32  memory address
- WriteData  out  32  B register, memory store data
- SrcA  out  32  ALU operand A
- SrcB  out  32  ALU operand B
- Result  out  32  writeback/PC-next value

## Operation
- PCWrite = NextPC | PCSrc. When PCWrite is high, PC <= Result; otherwise PC holds.
- IRWrite = 1: Instr <= ReadData; otherwise Instr holds.
- Free-running registers, loaded every cycle with no enable:
  - Data <= ReadData
  - A <= RD1
  - B <= RD2
  - ALUOut <= ALUResult
- Muxes are purely combinational from the register contents and the current inputs. Adr = AdrSrc ? Result : PC.
- Result selection uses the ResultSrc encoding above. Code 11 aliases 00 and is never X.
- All arithmetic is done outside this block. No width changes: every datapath is 32 bits, and constants 4 and 0 are 32-bit zero-extended.
- Simultaneous NextPC and PCSrc: one PC write of Result. There is no priority issue because both write the same source.
- Simultaneous IRWrite and PCWrite: both registers load in the same edge (the normal FETCH case). Instr takes pre-edge ReadData fetched from the old PC.

## Timing
- Reset values, applied asynchronously and immediately, including mid-instruction:
  - PC = RESET_PC
  - Instr = 0
  - Data, A, B, ALUOut = 0
  - Combinational outputs follow from these values.
- Leaving reset: the first rising edge with reset low performs normal updates.
- Latency:
  - Register outputs reflect their inputs 1 cycle after the capturing edge.
  - Mux outputs have 0-cycle latency.
- Multicycle sequencing, with the FSM providing control:
  - FETCH (AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, NextPC=1): Instr <= mem[PC], PC <= PC+4.
  - DECODE: A/B capture the register operands, and ALUResult = PC+8 is available on Result for R15 reads.
  - MEMADR/MEMRD: Adr = ALUOut via ResultSrc=00, AdrSrc=1. Data captures ReadData on the next edge.
  - MEMWB: Result = Data.
- Combinational path ALUResult -> Result -> Adr/PC.D exists by design when ResultSrc=10. It must close timing in one cycle together with the ALU.
- No handshake. Memory is assumed zero-wait: ReadData is valid in the same cycle as Adr.

## Test plan
- Reset, then hold reset low with all enables at 0 for 3 cycles -> PC=RESET_PC, Instr=0, Adr=RESET_PC, SrcB=0 for ALUSrcB=11.
- FETCH sequence:
  - Stimulus: PC=0, ReadData=32'hE2811005, IRWrite=1, NextPC=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUResult driven as SrcA+SrcB.
  - Response: after one edge, Instr=32'hE2811005 and PC=4. In the next cycle with the same muxes, Result=8.
- Load path:
  - Stimulus: ALUResult=32'h100 latched into ALUOut, then AdrSrc=1, ResultSrc=00.
  - Response: Adr=32'h100. ReadData=32'hDEAD_BEEF is captured into Data one edge later, and ResultSrc=01 gives Result=32'hDEAD_BEEF.
- Branch not taken vs taken with NextPC=0, ResultSrc=10, ALUResult=32'h40:
  - PCSrc=0 -> PC unchanged.
  - PCSrc=1 -> PC=32'h40 after one edge.
- Operand registers:
  - Stimulus: RD1=7, RD2=9, then ALUSrcA=00 and ALUSrcB=00.
  - Response: SrcA=7, SrcB=9, WriteData=9 one cycle after RD1/RD2 are applied. ALUSrcB=01 with ExtImm=32'hFF gives SrcB=32'hFF.
- Asynchronous reset mid-instruction:
  - Stimulus: PC=32'h20, Instr nonzero, assert reset between edges.
  - Response: PC=RESET_PC and Instr=0 before the next clock edge, with no dependence on clk.

Source files
------------

// File: rtl/mc_seqregs_if.sv
// rtl/mc_seqregs_if.sv - control and datapath bundle between FSM/memory/ALU and the sequential register stage
//
// Groups the FSM control fields, incoming datapath values and the register/mux
// outputs of mc_seqregs.
//   master : FSM, memory, register file and ALU side (drives controls and data in)
//   slave  : mc_seqregs (drives PC, Instr, Adr, WriteData, SrcA, SrcB, Result)
interface mc_seqregs_if;
    logic        NextPC;
    logic        PCSrc;
    logic        IRWrite;
    logic        AdrSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [31:0] ReadData;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] ExtImm;
    logic [31:0] ALUResult;
    logic [31:0] PC;
    logic [31:0] Instr;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [31:0] Result;

    modport master (
        output NextPC, PCSrc, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
        output ReadData, RD1, RD2, ExtImm, ALUResult,
        input  PC, Instr, Adr, WriteData, SrcA, SrcB, Result
    );

    modport slave (
        input  NextPC, PCSrc, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
        input  ReadData, RD1, RD2, ExtImm, ALUResult,
        output PC, Instr, Adr, WriteData, SrcA, SrcB, Result
    );
endinterface

// File: rtl/mc_seqregs.sv
// rtl/mc_seqregs.sv - multicycle ARM sequential datapath registers and operand/result muxes
//
// Holds PC, Instr and the non-architectural Data, A, B and ALUOut registers and
// steers the address, ALU operand and result muxes from the FSM control fields.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous active-high reset
//   bus   : mc_seqregs_if.slave - control fields and data in, register/mux values out
module mc_seqregs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    mc_seqregs_if.slave  bus
);

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_data;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_aluout;

    logic        w_pc_write;
    logic [31:0] w_srca;
    logic [31:0] w_srcb;
    logic [31:0] w_result;

    // Fetch increment and condition-qualified branch both write Result, so
    // a simple OR is enough when they coincide.
    assign w_pc_write = bus.NextPC | bus.PCSrc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_instr  <= 32'd0;
            r_data   <= 32'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_aluout <= 32'd0;
        end else begin
            if (w_pc_write) begin
                r_pc <= w_result;
            end
            // During FETCH this samples ReadData addressed by the pre-edge PC.
            if (bus.IRWrite) begin
                r_instr <= bus.ReadData;
            end
            r_data   <= bus.ReadData;
            r_a      <= bus.RD1;
            r_b      <= bus.RD2;
            r_aluout <= bus.ALUResult;
        end
    end

    always_comb begin
        w_srca = 32'd0;
        unique case (bus.ALUSrcA)
            2'b00:   w_srca = r_a;
            2'b01:   w_srca = r_pc;
            2'b10:   w_srca = r_aluout;
            default: w_srca = 32'd0;
        endcase
    end

    always_comb begin
        w_srcb = 32'd0;
        unique case (bus.ALUSrcB)
            2'b00:   w_srcb = r_b;
            2'b01:   w_srcb = bus.ExtImm;
            2'b10:   w_srcb = 32'd4;
            default: w_srcb = 32'd0;
        endcase
    end

    // Code 11 aliases ALUOut so the result never floats to an unknown.
    // ResultSrc=10 is the intentional ALU -> Result -> Adr/PC combinational path.
    always_comb begin
        w_result = r_aluout;
        unique case (bus.ResultSrc)
            2'b01:   w_result = r_data;
            2'b10:   w_result = bus.ALUResult;
            default: w_result = r_aluout;
        endcase
    end

    assign bus.PC        = r_pc;
    assign bus.Instr     = r_instr;
    assign bus.Adr       = bus.AdrSrc ? w_result : r_pc;
    assign bus.WriteData = r_b;
    assign bus.SrcA      = w_srca;
    assign bus.SrcB      = w_srcb;
    assign bus.Result    = w_result;

endmodule
